n64_console_host: RTL and testbench
===================================

// Module: n64_console_host
// PURPOSE
//  Console-side master for the N64 single-wire controller bus. On a start request it
//  sends a one-byte command, then releases the line and decodes the controller reply.
//  Poll (0x01) replies return button and stick state; info/reset (0x00/0xFF) replies
//  return the 24-bit status. Used to test-drive the n64_controller emulator and to
//  read real pads. The line is open-drain: this block only pulls it low or releases it.
// PARAMETERS
//  CLKS_PER_US  4    sample_clk cycles per microsecond (bus bit time = 4*CLKS_PER_US clocks)
//  TIMEOUT_US   100  max wait for a reply falling edge, or for any single line level in a reply
// PORTS
//  sample_clk    in   1   sole clock; all logic on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  start         in   1   1-cycle request; sampled only in IDLE
//  cmd           in   8   command byte, captured with start
//  data_rx       in   1   raw bus level (asynchronous; 2-flop synchronized internally)
//  drive_low     out  1   1 = pull bus low, 0 = release
//  busy          out  1   high from cycle after accepted start until resp_valid/err pulse
//  resp_valid    out  1   1-cycle pulse, reply decoded OK
//  resp_data     out  32  reply bits MSB-first, right-aligned (24-bit reply in [23:0], [31:24]=0)
//  button_state  out  16  resp_data[31:16] of last good 0x01 reply
//  stick_state   out  16  resp_data[15:0] of last good 0x01 reply
//  err           out  1   1-cycle pulse: timeout, bad reply framing, or unsupported cmd
// BEHAVIOUR
//  Reset: drive_low=0, busy=0, resp_valid=0, err=0, resp_data/button_state/stick_state=0,
//   state=IDLE, sync flops=1. Reset mid-transfer releases the line immediately (async).
//  Timing unit U=CLKS_PER_US clocks. Bit '0': low 3U, release 1U. Bit '1': low 1U, release 3U.
//  Reply length by cmd: 0x01 -> 32 bits; 0x00, 0xFF -> 24 bits; any other -> rejected.
//  States:
//   IDLE:    start & supported cmd -> TX_BIT (bit 7) with drive_low=1 on next cycle;
//            start & unsupported cmd -> err pulse next cycle, stay IDLE, no line activity;
//            start while not IDLE is ignored.
//   TX_BIT:  8 bits MSB first, 4U clocks each, back-to-back; after bit 0 -> TX_STOP.
//   TX_STOP: low 1U, then release; -> RX_WAIT on the first released cycle.
//   RX_WAIT: wait for synced falling edge; none within TIMEOUT_US*U clocks -> ERROR.
//   RX_BIT:  sample synced line 2U clocks after falling edge (low=0, high=1), shift into
//            resp shift register; wait for rising edge, then next falling edge. After the
//            last expected bit -> RX_STOP on the next falling edge.
//   RX_STOP: controller stop bit (low ~2U); on synced rising edge -> DONE.
//   DONE:    1 cycle: resp_valid=1, resp_data updated; for 0x01 also button/stick; -> IDLE.
//   ERROR:   1 cycle: err=1, outputs other than busy/err unchanged; -> IDLE.
//  Any level (low or high) held > TIMEOUT_US*U clocks inside RX_BIT/RX_STOP -> ERROR.
//  A rising edge before the 2U sample point is still sampled at 2U (reads 1) - no error.
//  Extra edges after RX_STOP are ignored (block is in IDLE, line not examined).
//  drive_low is never 1 outside TX_BIT/TX_STOP; data_rx is not examined during TX.
//  Counter widths sized from parameters ($clog2(TIMEOUT_US*CLKS_PER_US+1)); no wrap.
//  Latency: start at cycle N -> drive_low=1 at N+1; TX frame = 33U clocks + 1 cycle.
// TESTING
//  1 start,cmd=0x01 -> drive_low pattern 0000_0001+stop: 7x(low 12,high 4), low 4/high 12,
//    low 4 then release (CLKS_PER_US=4); busy high throughout.
//  2 bench controller replies 0x8000_7F81 to 0x01 -> resp_valid 1 pulse, resp_data=0x80007F81,
//    button_state=0x8000, stick_state=0x7F81.
//  3 cmd=0xFF, 24-bit reply 0x050002 -> resp_data=0x00050002, button/stick unchanged.
//  4 cmd=0x01, no reply -> err pulse exactly 400 clocks after release, busy drops same cycle.
//  5 cmd=0x42 -> err pulse next cycle, drive_low stays 0, busy stays 0.
//  6 rst_n low mid-bit 3 of TX -> drive_low=0 immediately; after release, fresh 0x01 works.

Source files
------------

// File: rtl/n64_console_host.sv
// Console-side master for the N64 single-wire controller bus.
// Sends a one-byte command on an open-drain line, then decodes the controller
// reply: 32 bits for poll (0x01), 24 bits for info/reset (0x00/0xFF).
module n64_console_host #(
  parameter int CLKS_PER_US = 4,
  parameter int TIMEOUT_US  = 100
) (
  input  logic        sample_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        data_rx,
  output logic        drive_low,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [15:0] button_state,
  output logic [15:0] stick_state,
  output logic        err
);

  localparam int TO_CLKS = TIMEOUT_US * CLKS_PER_US;
  localparam int CW      = $clog2(TO_CLKS + 1);

  localparam logic [CW-1:0] BIT_LAST    = CW'(4 * CLKS_PER_US - 1);
  localparam logic [CW-1:0] STOP_LAST   = CW'(CLKS_PER_US - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(2 * CLKS_PER_US - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TO_CLKS - 1);
  localparam logic [CW-1:0] ONE_LOW     = CW'(CLKS_PER_US);
  localparam logic [CW-1:0] ZERO_LOW    = CW'(3 * CLKS_PER_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_BIT,
    S_TX_STOP,
    S_RX_WAIT,
    S_RX_BIT,
    S_RX_STOP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;        // TX bit-time / RX wait / sample-point counter
  logic [CW-1:0] lvl_cnt;    // clocks since last line edge during reply
  logic [2:0]    bit_idx;
  logic [7:0]    tx_byte;
  logic [31:0]   rx_sreg;
  logic [5:0]    rx_count;
  logic [5:0]    rx_len;
  logic          is_poll;
  logic          sampled;

  logic          sync1, sync2, rx_d;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] tx_low_len;
  logic          fell, rose, any_edge;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= data_rx;
      sync2 <= sync1;
      rx_d  <= sync2;
    end
  end

  // Edge decode, counter increment and current TX bit low time
  always_comb begin
    cnt_nx     = cnt + CW'(1);
    tx_low_len = tx_byte[bit_idx] ? ONE_LOW : ZERO_LOW;
    fell       = rx_d & ~sync2;
    rose       = ~rx_d & sync2;
    any_edge   = rx_d ^ sync2;
  end

  // Transfer FSM; drive_low is computed one cycle ahead so it is registered
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lvl_cnt      <= '0;
      bit_idx      <= '0;
      tx_byte      <= '0;
      rx_sreg      <= '0;
      rx_count     <= '0;
      rx_len       <= '0;
      is_poll      <= 1'b0;
      sampled      <= 1'b0;
      drive_low    <= 1'b0;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      button_state <= '0;
      stick_state  <= '0;
      err          <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cmd == 8'h01 || cmd == 8'h00 || cmd == 8'hFF) begin
              state     <= S_TX_BIT;
              tx_byte   <= cmd;
              bit_idx   <= 3'd7;
              cnt       <= '0;
              drive_low <= 1'b1;
              busy      <= 1'b1;
              is_poll   <= (cmd == 8'h01);
              rx_len    <= (cmd == 8'h01) ? 6'd32 : 6'd24;
              rx_sreg   <= '0;
              rx_count  <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_TX_BIT: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            drive_low <= 1'b1;
            if (bit_idx == 3'd0) state <= S_TX_STOP;
            else                 bit_idx <= bit_idx - 3'd1;
          end else begin
            cnt       <= cnt_nx;
            drive_low <= (cnt_nx < tx_low_len);
          end
        end
        S_TX_STOP: begin
          if (cnt == STOP_LAST) begin
            state     <= S_RX_WAIT;
            drive_low <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt_nx;
          end
        end
        S_RX_WAIT: begin
          if (fell) begin
            state   <= S_RX_BIT;
            cnt     <= '0;
            lvl_cnt <= '0;
            sampled <= 1'b0;
          end else if (cnt == TO_LAST) begin
            state <= S_ERROR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt_nx;
          end
        end
        S_RX_BIT: begin
          if (!any_edge && lvl_cnt == TO_LAST) begin
            state <= S_ERROR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            lvl_cnt <= any_edge ? '0 : lvl_cnt + CW'(1);
            if (fell) begin
              if (!sampled) begin
                state <= S_ERROR;
                err   <= 1'b1;
                busy  <= 1'b0;
              end else if (rx_count == rx_len) begin
                state <= S_RX_STOP;
              end else begin
                cnt     <= '0;
                sampled <= 1'b0;
              end
            end else if (!sampled) begin
              if (cnt == SAMPLE_LAST) begin
                rx_sreg  <= {rx_sreg[30:0], sync2};
                rx_count <= rx_count + 6'd1;
                sampled  <= 1'b1;
              end else begin
                cnt <= cnt_nx;
              end
            end
          end
        end
        S_RX_STOP: begin
          if (rose) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            busy       <= 1'b0;
            resp_data  <= rx_sreg;
            if (is_poll) begin
              button_state <= rx_sreg[31:16];
              stick_state  <= rx_sreg[15:0];
            end
          end else if (lvl_cnt == TO_LAST) begin
            state <= S_ERROR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            lvl_cnt <= lvl_cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_console_host.sv
// Bench for n64_console_host: wired-AND bus with a behavioural controller,
// reference model of expected replies, directed cases then random transactions.
module tb_n64_console_host;

  localparam int CPU = 4;
  localparam int TOU = 100;
  localparam int U   = CPU;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        ctrl_low = 1'b0;
  logic        data_rx;
  logic        drive_low, busy, resp_valid, err;
  logic [31:0] resp_data;
  logic [15:0] button_state, stick_state;

  assign data_rx = ~(drive_low | ctrl_low);

  always #5 clk = ~clk;

  n64_console_host #(.CLKS_PER_US(CPU), .TIMEOUT_US(TOU)) dut (
    .sample_clk  (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cmd         (cmd),
    .data_rx     (data_rx),
    .drive_low   (drive_low),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .button_state(button_state),
    .stick_state (stick_state),
    .err         (err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;

  logic [31:0] m_resp = '0;
  logic [15:0] m_btn  = '0;
  logic [15:0] m_stk  = '0;

  // Count cycles each pulse output is high
  always @(negedge clk) begin
    if (resp_valid) n_valid++;
    if (err)        n_err++;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] c);
    @(negedge clk);
    cmd   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd   = 8'($urandom);
  endtask

  // Capture 133 cycles: 32U of command bits, U of stop, first released cycle
  task automatic tx_phase(input logic [7:0] c);
    logic [132:0] wave, exp;
    int idx, lo, nb;
    wave = '0;
    exp  = '0;
    nb   = 0;
    for (int i = 0; i < 133; i++) begin
      wave[i] = drive_low;
      if (!busy) nb++;
      if (i < 132) @(negedge clk);
    end
    idx = 0;
    for (int b = 7; b >= 0; b--) begin
      lo = c[b] ? U : 3 * U;
      for (int t = 0; t < 4 * U; t++) begin
        exp[idx] = (t < lo);
        idx++;
      end
    end
    for (int t = 0; t < U; t++) begin
      exp[idx] = 1'b1;
      idx++;
    end
    check("tx_wave", 160'(wave), 160'(exp));
    check("tx_busy_low_cycles", 160'(nb), 160'(0));
  endtask

  task automatic ctrl_reply(input logic [31:0] v, input int nbits);
    int lo;
    for (int i = nbits - 1; i >= 0; i--) begin
      lo = (v[i] ? U : 3 * U) + int'($urandom_range(0, 2)) - 1;
      ctrl_low = 1'b1;
      repeat (lo) @(negedge clk);
      ctrl_low = 1'b0;
      repeat (4 * U - lo) @(negedge clk);
    end
    ctrl_low = 1'b1;
    repeat (2 * U) @(negedge clk);
    ctrl_low = 1'b0;
  endtask

  task automatic full_txn(input logic [7:0] c, input logic [31:0] v_in, input bit reply);
    int nbits, v0, e0, k;
    logic [31:0] v;
    nbits = (c == 8'h01) ? 32 : 24;
    v     = (nbits == 24) ? (v_in & 32'h00FF_FFFF) : v_in;
    v0    = n_valid;
    e0    = n_err;
    issue(c);
    tx_phase(c);
    if (reply) begin
      repeat ($urandom_range(6, 40)) @(negedge clk);
      ctrl_reply(v, nbits);
      k = 0;
      while (!(resp_valid || err) && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("done_in_time", 160'(k < 40), 160'(1));
      check("busy_at_done", 160'(busy), 160'(0));
      repeat (2) @(negedge clk);
      m_resp = v;
      if (c == 8'h01) begin
        m_btn = v[31:16];
        m_stk = v[15:0];
      end
      check("valid_pulse_cycles", 160'(n_valid - v0), 160'(1));
      check("err_pulse_cycles", 160'(n_err - e0), 160'(0));
    end else begin
      k = 0;
      while (!err && k < 600) begin
        @(negedge clk);
        k++;
      end
      check("timeout_clocks", 160'(k), 160'(400));
      check("busy_at_err", 160'(busy), 160'(0));
      repeat (2) @(negedge clk);
      check("err_pulse_cycles", 160'(n_err - e0), 160'(1));
      check("valid_pulse_cycles", 160'(n_valid - v0), 160'(0));
    end
    check("resp_data", 160'(resp_data), 160'(m_resp));
    check("button_state", 160'(button_state), 160'(m_btn));
    check("stick_state", 160'(stick_state), 160'(m_stk));
    repeat ($urandom_range(2, 10)) @(negedge clk);
  endtask

  task automatic bad_cmd(input logic [7:0] c);
    int nd;
    issue(c);
    check("bad_err", 160'(err), 160'(1));
    check("bad_busy", 160'(busy), 160'(0));
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drive_low || busy || err) nd++;
    end
    check("bad_line_quiet", 160'(nd), 160'(0));
  endtask

  initial begin
    logic [7:0] c;
    int r;
    repeat (3) @(negedge clk);
    check("rst_drive_low", 160'(drive_low), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_resp_valid", 160'(resp_valid), 160'(0));
    check("rst_err", 160'(err), 160'(0));
    check("rst_resp_data", 160'(resp_data), 160'(0));
    check("rst_buttons", 160'({button_state, stick_state}), 160'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    full_txn(8'h01, 32'h8000_7F81, 1'b1);
    full_txn(8'hFF, 32'h0005_0002, 1'b1);
    full_txn(8'h01, 32'h0, 1'b0);
    bad_cmd(8'h42);

    // Reset in the middle of command bit 3
    issue(8'h01);
    repeat (70) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_drive_low", 160'(drive_low), 160'(0));
    check("midrst_busy", 160'(busy), 160'(0));
    m_resp = '0;
    m_btn  = '0;
    m_stk  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    full_txn(8'h01, 32'h1234_ABCD, 1'b1);

    for (int n = 0; n < 12; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        3: full_txn(8'h00, $urandom, 1'b1);
        4: full_txn(8'hFF, $urandom, 1'b1);
        5: begin
          c = 8'($urandom);
          if (c == 8'h00 || c == 8'h01 || c == 8'hFF) c = 8'h42;
          bad_cmd(c);
        end
        6: full_txn(8'h00, 32'h0, 1'b0);
        default: full_txn(8'h01, $urandom, 1'b1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
